sha_digest_cmp: RTL and testbench

- Sits directly downstream of the 8-word serial-to-parallel digest shift register in the SHA output path.
- Counts the 32-bit word strobes that load that register, and captures the candidate nonce.
- Once the 256-bit digest is complete, compares it against the mining target one 32-bit slice per cycle, most-significant slice first, with early exit.
- Presents a held found/not-found result to the host-side controller through a valid/ack handshake.

---
 rtl/sha_digest_cmp_if.sv | 30 +++
 rtl/sha_digest_cmp.sv | 119 +++++++++++
 tb/tb_sha_digest_cmp.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sha_digest_cmp_if.sv
// Handshake and data bundle between the SHA digest path, the host controller
// and the digest comparator. The master side drives the digest/target/strobe
// and ack. The slave side (the comparator) returns status and result.
interface sha_digest_cmp_if #(
  parameter int NUM_WORDS = 8,
  parameter int WORD_W    = 32
);
  localparam int DIG_W = NUM_WORDS * WORD_W;

  logic              word_strobe;
  logic [WORD_W-1:0] nonce_in;
  logic [DIG_W-1:0]  digest;
  logic [DIG_W-1:0]  target;
  logic              result_ack;
  logic              busy;
  logic              result_valid;
  logic              hash_found;
  logic [WORD_W-1:0] found_nonce;
  logic              overrun;

  modport master (
    output word_strobe, nonce_in, digest, target, result_ack,
    input  busy, result_valid, hash_found, found_nonce, overrun
  );

  modport slave (
    input  word_strobe, nonce_in, digest, target, result_ack,
    output busy, result_valid, hash_found, found_nonce, overrun
  );
endinterface

// File: rtl/sha_digest_cmp.sv
// Digest comparator. It counts the word strobes that fill the digest shift
// register and latches the nonce on the last word. After one settle cycle it
// compares digest against target one slice per cycle, most significant slice
// first, and exits early. The found/not-found result is held until the host
// acknowledges it.
module sha_digest_cmp #(
  parameter int NUM_WORDS = 8,
  parameter int WORD_W    = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  sha_digest_cmp_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COMPARE,
    S_RESULT
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  r_slice_idx;
  logic              r_busy;
  logic              r_result_valid;
  logic              r_hash_found;
  logic [WORD_W-1:0] r_found_nonce;
  logic              r_overrun;

  logic [WORD_W-1:0] w_d;
  logic [WORD_W-1:0] w_t;

  assign w_d = bus.digest[r_slice_idx*WORD_W +: WORD_W];
  assign w_t = bus.target[r_slice_idx*WORD_W +: WORD_W];

  assign bus.busy         = r_busy;
  assign bus.result_valid = r_result_valid;
  assign bus.hash_found   = r_hash_found;
  assign bus.found_nonce  = r_found_nonce;
  assign bus.overrun      = r_overrun;

  // Control FSM. Every output is registered and updated together with the
  // state, so busy/result_valid follow the state with no decode glitches.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= S_IDLE;
      r_word_cnt     <= '0;
      r_slice_idx    <= LAST;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_hash_found   <= 1'b0;
      r_found_nonce  <= '0;
      r_overrun      <= 1'b0;
    end else begin
      // A strobe that arrives outside IDLE is lost. Flag it, and keep it
      // flagged until reset.
      if (bus.word_strobe && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.word_strobe) begin
            if (r_word_cnt == LAST) begin
              r_found_nonce <= bus.nonce_in;
              r_word_cnt    <= '0;
              r_state       <= S_SETTLE;
              r_busy        <= 1'b1;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end

        // The final shift lands on digest during this cycle.
        S_SETTLE: begin
          r_slice_idx <= LAST;
          r_state     <= S_COMPARE;
        end

        S_COMPARE: begin
          if (w_d < w_t) begin
            r_hash_found   <= 1'b1;
            r_state        <= S_RESULT;
            r_result_valid <= 1'b1;
          end else if (w_d > w_t) begin
            r_hash_found   <= 1'b0;
            r_state        <= S_RESULT;
            r_result_valid <= 1'b1;
          end else if (r_slice_idx == '0) begin
            // All slices are equal, and equality counts as meeting target.
            r_hash_found   <= 1'b1;
            r_state        <= S_RESULT;
            r_result_valid <= 1'b1;
          end else begin
            r_slice_idx <= r_slice_idx - 1'b1;
          end
        end

        S_RESULT: begin
          if (bus.result_ack) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
          end
        end

        default: begin
          r_state        <= S_IDLE;
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha_digest_cmp.sv
// Randomised self-checking bench for sha_digest_cmp. The expected result is
// the full 256-bit unsigned comparison. The expected latency is derived from
// the count of leading equal slices.
module tb_sha_digest_cmp;
  localparam int NW = 8;
  localparam int WW = 32;
  localparam int DW = NW * WW;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  sha_digest_cmp_if #(.NUM_WORDS(NW), .WORD_W(WW)) bus ();

  sha_digest_cmp #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_ovr  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the result is a plain unsigned comparison of the whole digest.
  function automatic logic ref_found(input logic [DW-1:0] d, input logic [DW-1:0] t);
    return d <= t;
  endfunction

  // Reference: two cycles of fixed overhead, plus one cycle for each leading
  // slice that is equal. The last slice always decides.
  function automatic int ref_latency(input logic [DW-1:0] d, input logic [DW-1:0] t);
    int m = 0;
    for (int i = NW - 1; i > 0; i--) begin
      if (d[i*WW +: WW] == t[i*WW +: WW]) m++;
      else break;
    end
    return 2 + m;
  endfunction

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int i = 0; i < NW; i++) v[i*WW +: WW] = $urandom;
    return v;
  endfunction

  // One strobe, sampled at the posedge. The task returns on the following
  // negedge.
  task automatic strobe_once();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk) bus.word_strobe = 1'b1;
    @(negedge clk) bus.word_strobe = 1'b0;
  endtask

  // Issue (NW - pre) strobes for this digest and wait for the result. An
  // optional extra strobe is injected while busy (ovr_at >= 0). The result is
  // held for 'hold' cycles, and then acknowledged.
  task automatic run_digest(input logic [DW-1:0] d, input logic [DW-1:0] t,
                            input logic [WW-1:0] nonce, input int pre,
                            input int ovr_at, input int hold, input bit ack_strobe);
    int  lat;
    int  exp_lat;
    logic exp_f;
    exp_lat = ref_latency(d, t);
    exp_f   = ref_found(d, t);
    bus.digest = d;
    bus.target = t;
    for (int i = pre; i < NW; i++) begin
      bus.nonce_in = (i == NW - 1) ? nonce : $urandom;
      strobe_once();
    end
    bus.nonce_in = $urandom;
    chk("busy_after_e0", bus.busy, 1'b1);
    chk("valid_after_e0", bus.result_valid, 1'b0);
    lat = 0;
    while (!bus.result_valid && lat < 20) begin
      bus.word_strobe = (lat == ovr_at);
      @(negedge clk);
      lat++;
    end
    bus.word_strobe = 1'b0;
    if (ovr_at >= 0) exp_ovr = 1'b1;
    chk("latency", lat, exp_lat);
    chk("hash_found", bus.hash_found, exp_f);
    chk("found_nonce", bus.found_nonce, nonce);
    chk("overrun", bus.overrun, exp_ovr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", bus.result_valid, 1'b1);
      chk("hold_found", bus.hash_found, exp_f);
      chk("hold_nonce", bus.found_nonce, nonce);
    end
    bus.result_ack  = 1'b1;
    bus.word_strobe = ack_strobe;
    @(negedge clk);
    bus.result_ack  = 1'b0;
    bus.word_strobe = 1'b0;
    if (ack_strobe) exp_ovr = 1'b1;
    chk("busy_after_ack", bus.busy, 1'b0);
    chk("valid_after_ack", bus.result_valid, 1'b0);
    chk("found_kept", bus.hash_found, exp_f);
    chk("nonce_kept", bus.found_nonce, nonce);
    chk("overrun_after_ack", bus.overrun, exp_ovr);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] t;
    int k;
    bus.word_strobe = 1'b0;
    bus.nonce_in    = '0;
    bus.digest      = '0;
    bus.target      = '0;
    bus.result_ack  = 1'b0;

    // Check the state held under reset.
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_valid", bus.result_valid, 1'b0);
    chk("rst_found", bus.hash_found, 1'b0);
    chk("rst_nonce", bus.found_nonce, 32'h0);
    chk("rst_overrun", bus.overrun, 1'b0);
    n_rst = 1'b1;
    @(negedge clk);

    // The most significant slice is below target.
    t = rand_wide(); t[255:224] = 32'h00000FFF;
    d = rand_wide(); d[255:224] = 32'h00000000;
    run_digest(d, t, 32'hDEADBEEF, 0, -1, 5, 1'b0);

    // The most significant slice is above target.
    d[255:224] = 32'h00001000;
    run_digest(d, t, $urandom, 0, -1, 1, 1'b0);

    // Digest equals target in every bit, which is the worst-case latency.
    t = rand_wide();
    run_digest(t, t, $urandom, 0, -1, 0, 1'b0);

    // Digest is one above target in slice 0 only.
    t = rand_wide(); t[31:0] = 32'h12345678;
    d = t; d[31:0] = 32'h12345679;
    run_digest(d, t, $urandom, 0, -1, 2, 1'b0);

    // A strobe during COMPARE sets overrun, and leaves the word count alone.
    t = rand_wide();
    run_digest(t, t, $urandom, 0, 3, 1, 1'b0);
    for (int i = 0; i < NW - 1; i++) strobe_once();
    chk("seven_strobes_idle", bus.busy, 1'b0);
    d = rand_wide();
    run_digest(d, t, $urandom, NW - 1, -1, 0, 1'b0);

    // A strobe that coincides with ack is dropped, and overrun stays set.
    d = rand_wide();
    run_digest(d, t, $urandom, 0, -1, 1, 1'b1);
    for (int i = 0; i < NW - 1; i++) strobe_once();
    chk("seven_strobes_idle2", bus.busy, 1'b0);
    run_digest(d, t, $urandom, NW - 1, -1, 0, 1'b0);

    // Reset during COMPARE aborts at once, with no clock edge needed.
    t = rand_wide();
    bus.digest = t;
    bus.target = t;
    for (int i = 0; i < NW; i++) strobe_once();
    repeat (4) @(negedge clk);
    chk("mid_busy", bus.busy, 1'b1);
    n_rst = 1'b0;
    #1;
    chk("async_busy", bus.busy, 1'b0);
    chk("async_valid", bus.result_valid, 1'b0);
    chk("async_overrun", bus.overrun, 1'b0);
    chk("async_nonce", bus.found_nonce, 32'h0);
    exp_ovr = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_result_after_rst", bus.result_valid, 1'b0);
    chk("idle_after_rst", bus.busy, 1'b0);

    // Randomised digests, with a random depth of leading equal slices.
    for (int n = 0; n < 24; n++) begin
      t = rand_wide();
      d = t;
      k = $urandom_range(0, NW);
      if (k < NW) d[k*WW +: WW] = $urandom_range(0, 3) == 0 ? t[k*WW +: WW] + 1 : $urandom;
      if ($urandom_range(0, 5) == 0) d = rand_wide();
      run_digest(d, t, $urandom, 0, -1, $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before limit");
    $fatal(1);
  end
endmodule
